// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STUFF,
        EOP_SE0_1,
        EOP_SE0_2,
        EOP_J
    } state_t;

    // Line states as {dplus, dminus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int DEF_STUFF_LEN = 6;

    function automatic logic [1:0] nrzi(input logic [1:0] line, input logic raw);
        if (raw) return line;
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Fractional bit timer: one strobe every BIT_NUM/BIT_DEN clocks on average.
module usb_bit_timer #(
    parameter int BIT_NUM = 25,
    parameter int BIT_DEN = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic bit_strobe
);
    localparam int AW = $clog2(BIT_NUM + BIT_DEN + 1);

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;

    assign acc_sum    = acc + AW'(BIT_DEN);
    assign bit_strobe = enable && (acc_sum >= AW'(BIT_NUM));

    always_ff @(posedge clk) begin
        if (!n_rst || clear)
            acc <= '0;
        else if (enable)
            acc <= bit_strobe ? acc_sum - AW'(BIT_NUM) : acc_sum;
    end

endmodule

// File: rtl/usb_tx_serializer.sv
// Parallel-to-serial USB full-speed transmitter: bit stuffing, NRZI and EOP,
// with a single-byte holding register in front of the shift register.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int BIT_NUM   = 25,
    parameter int BIT_DEN   = 3,
    parameter int STUFF_LEN = DEF_STUFF_LEN
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_enable,
    input  logic [7:0] data_pts,
    input  logic       eop_request,
    output logic       dplus,
    output logic       dminus,
    output logic       byte_complete,
    output logic       eop_done,
    output logic       busy,
    output logic       underrun,
    output logic       overrun
);
    localparam int OW = $clog2(STUFF_LEN + 1);

    state_t        state, state_n;
    logic [7:0]    sh, sh_n, hold_data, hold_data_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [OW-1:0] ones, ones_n, ones_nx;
    logic [1:0]    line, line_n;
    logic          hold_valid, hold_valid_n, eop_pending, eop_pending_n;
    logic          busy_n, bc_n, ur_n, ed_n, ov_n;
    logic          bit_strobe, xfer, byte_end, eop_end;

    usb_bit_timer #(.BIT_NUM(BIT_NUM), .BIT_DEN(BIT_DEN)) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (state == IDLE),
        .enable     (state != IDLE),
        .bit_strobe (bit_strobe)
    );

    assign ones_nx = sh[0] ? ones + 1'b1 : '0;
    assign dplus   = line[1];
    assign dminus  = line[0];

    always_comb begin
        state_n       = state;
        sh_n          = sh;
        bit_cnt_n     = bit_cnt;
        ones_n        = ones;
        line_n        = line;
        busy_n        = busy;
        eop_pending_n = eop_pending | (eop_request && state != IDLE);
        bc_n          = 1'b0;
        ur_n          = 1'b0;
        ed_n          = 1'b0;
        xfer          = 1'b0;
        byte_end      = 1'b0;
        eop_end       = 1'b0;

        case (state)
            IDLE: if (hold_valid) begin
                xfer      = 1'b1;
                sh_n      = hold_data;
                bit_cnt_n = '0;
                ones_n    = '0;
                busy_n    = 1'b1;
                line_n    = nrzi(LINE_J, hold_data[0]);
                state_n   = SHIFT;
            end
            SHIFT: if (bit_strobe) begin
                ones_n = ones_nx;
                if (ones_nx == OW'(STUFF_LEN)) begin
                    // Bit index is held; STUFF resumes from the same position.
                    line_n  = nrzi(line, 1'b0);
                    state_n = STUFF;
                end else if (bit_cnt == 3'd7) begin
                    byte_end = 1'b1;
                end else begin
                    sh_n      = sh >> 1;
                    bit_cnt_n = bit_cnt + 3'd1;
                    line_n    = nrzi(line, sh[1]);
                end
            end
            STUFF: if (bit_strobe) begin
                ones_n  = '0;
                state_n = SHIFT;
                if (bit_cnt == 3'd7) begin
                    byte_end = 1'b1;
                end else begin
                    sh_n      = sh >> 1;
                    bit_cnt_n = bit_cnt + 3'd1;
                    line_n    = nrzi(line, sh[1]);
                end
            end
            EOP_SE0_1: if (bit_strobe) state_n = EOP_SE0_2;
            EOP_SE0_2: if (bit_strobe) begin
                line_n  = LINE_J;
                state_n = EOP_J;
            end
            EOP_J: if (bit_strobe) begin
                ed_n          = 1'b1;
                busy_n        = 1'b0;
                eop_pending_n = 1'b0;
                eop_end       = 1'b1;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (byte_end) begin
            bc_n = 1'b1;
            if (eop_pending_n) begin
                line_n  = LINE_SE0;
                state_n = EOP_SE0_1;
            end else if (hold_valid) begin
                // ones carries over so stuffing spans byte boundaries
                xfer      = 1'b1;
                sh_n      = hold_data;
                bit_cnt_n = '0;
                line_n    = nrzi(line, hold_data[0]);
                state_n   = SHIFT;
            end else begin
                ur_n    = 1'b1;
                busy_n  = 1'b0;
                line_n  = LINE_J;
                state_n = IDLE;
            end
        end

        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        ov_n         = 1'b0;
        if (xfer || eop_end) hold_valid_n = 1'b0;
        if (load_enable) begin
            if (hold_valid && !xfer && !eop_end) begin
                ov_n = 1'b1;
            end else begin
                hold_data_n  = data_pts;
                hold_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            sh            <= '0;
            bit_cnt       <= '0;
            ones          <= '0;
            line          <= LINE_J;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            eop_pending   <= 1'b0;
            busy          <= 1'b0;
            byte_complete <= 1'b0;
            underrun      <= 1'b0;
            eop_done      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_n;
            sh            <= sh_n;
            bit_cnt       <= bit_cnt_n;
            ones          <= ones_n;
            line          <= line_n;
            hold_data     <= hold_data_n;
            hold_valid    <= hold_valid_n;
            eop_pending   <= eop_pending_n;
            busy          <= busy_n;
            byte_complete <= bc_n;
            underrun      <= ur_n;
            eop_done      <= ed_n;
            overrun       <= ov_n;
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: a bit-stream model fills a per-bit scoreboard
// that is drained one clock at a time against the D+/D- pair and pulses.
module tb_usb_tx_serializer;

    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

    logic       clk = 1'b0, n_rst = 1'b0, load_enable = 1'b0, eop_request = 1'b0;
    logic [7:0] data_pts = 8'h00;
    logic       dplus, dminus, byte_complete, eop_done, busy, underrun, overrun;

    usb_tx_serializer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .load_enable   (load_enable),
        .data_pts      (data_pts),
        .eop_request   (eop_request),
        .dplus         (dplus),
        .dminus        (dminus),
        .byte_complete (byte_complete),
        .eop_done      (eop_done),
        .busy          (busy),
        .underrun      (underrun),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ln;
        int         len;
        logic       bc, ur, ed, bsy;
    } item_t;

    item_t      exp_q[$];
    logic [7:0] byte_q[$];
    item_t      cur;
    int         cur_left = 0, cur_pos = 0, smp = 0;
    int         nvec = 0, nerr = 0;

    function automatic logic [1:0] tog(input logic [1:0] l);
        return (l == J) ? K : J;
    endfunction

    // 25/3 clocks per bit from timer clear: 9,8,8 repeating
    function automatic int dur(input int k);
        return (k % 3 == 0) ? 9 : 8;
    endfunction

    // Expected line stream for byte_q, ending in EOP or underrun.
    function automatic void build(input bit eop);
        logic [1:0] lvl;
        int         ones, k;
        logic       bc, b;
        lvl = J; ones = 0; k = 0; bc = 1'b0;
        foreach (byte_q[n]) begin
            for (int i = 0; i < 8; i++) begin
                b = byte_q[n][i];
                if (!b) lvl = tog(lvl);
                exp_q.push_back('{lvl, dur(k), bc, 1'b0, 1'b0, 1'b1});
                k++; bc = 1'b0;
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    lvl = tog(lvl);
                    exp_q.push_back('{lvl, dur(k), 1'b0, 1'b0, 1'b0, 1'b1});
                    k++; ones = 0;
                end
            end
            bc = 1'b1;
        end
        if (eop) begin
            exp_q.push_back('{SE0, dur(k), bc, 1'b0, 1'b0, 1'b1}); k++;
            exp_q.push_back('{SE0, dur(k), 1'b0, 1'b0, 1'b0, 1'b1}); k++;
            exp_q.push_back('{J, dur(k), 1'b0, 1'b0, 1'b0, 1'b1});
            exp_q.push_back('{J, 1, 1'b0, 1'b0, 1'b1, 1'b0});
        end else begin
            exp_q.push_back('{J, 1, bc, 1'b1, 1'b0, 1'b0});
        end
        byte_q.delete();
    endfunction

    // Pops the next expectation and samples the DUT on the following negedge.
    task automatic next_sample(output bit done, output int idx,
                               output logic [1:0] gl, output logic [1:0] el,
                               output logic [4:0] gf, output logic [4:0] ef);
        done = 1'b0; idx = smp; gl = '0; el = '0; gf = '0; ef = '0;
        if (cur_left == 0) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
                return;
            end
            cur = exp_q.pop_front();
            cur_left = cur.len;
            cur_pos = 0;
        end
        @(negedge clk);
        gl = {dplus, dminus};
        gf = {byte_complete, underrun, eop_done, busy, overrun};
        el = cur.ln;
        ef = {cur.bc && cur_pos == 0, cur.ur && cur_pos == 0, cur.ed && cur_pos == 0, cur.bsy, 1'b0};
        cur_pos++; cur_left--; smp++;
    endtask

    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        load_enable = 1'b1;
        data_pts = b;
        @(negedge clk);
        load_enable = 1'b0;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({dplus, dminus, byte_complete, underrun, eop_done, busy, overrun} !== 7'b1000000) begin
            nerr++;
            $display("FAIL reset: got %b want 1000000",
                     {dplus, dminus, byte_complete, underrun, eop_done, busy, overrun});
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit done; int idx; logic [1:0] gl, el; logic [4:0] gf, ef;
        load_byte(8'h55);
        repeat (28) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        nvec++;
        if ({dplus, dminus, byte_complete, underrun, eop_done, busy, overrun} !== 7'b1000000) begin
            nerr++;
            $display("FAIL mid_reset: got %b want 1000000",
                     {dplus, dminus, byte_complete, underrun, eop_done, busy, overrun});
        end
        repeat (12) @(negedge clk);
        nvec++;
        if ({dplus, dminus, busy} !== 3'b100) begin
            nerr++;
            $display("FAIL mid_reset_idle: got %b want 100", {dplus, dminus, busy});
        end
        smp = 0;
        byte_q = '{8'h80};
        build(1'b0);
        load_byte(8'h80);
        next_sample(done, idx, gl, el, gf, ef);
        while (!done) begin
            nvec++;
            if (gl !== el) begin nerr++; $display("FAIL restart line @%0d: got %b want %b", idx, gl, el); end
            nvec++;
            if (gf !== ef) begin nerr++; $display("FAIL restart flags @%0d: got %b want %b", idx, gf, ef); end
            next_sample(done, idx, gl, el, gf, ef);
        end
    endtask

    // Single byte terminated by EOP; eop_request arrives mid-byte.
    task automatic test_eop(input logic [7:0] b, input string nm);
        bit done; int idx; logic [1:0] gl, el; logic [4:0] gf, ef;
        smp = 0;
        byte_q = '{b};
        build(1'b1);
        load_byte(b);
        fork
            begin
                next_sample(done, idx, gl, el, gf, ef);
                while (!done) begin
                    nvec++;
                    if (gl !== el) begin nerr++; $display("FAIL %s line @%0d: got %b want %b", nm, idx, gl, el); end
                    nvec++;
                    if (gf !== ef) begin nerr++; $display("FAIL %s flags @%0d: got %b want %b", nm, idx, gf, ef); end
                    next_sample(done, idx, gl, el, gf, ef);
                end
            end
            begin
                repeat (20) @(negedge clk);
                eop_request = 1'b1;
                @(negedge clk);
                eop_request = 1'b0;
            end
        join
    endtask

    task automatic test_stuffing;
        bit done; int idx, bc_at; logic [1:0] gl, el; logic [4:0] gf, ef;
        smp = 0; bc_at = -1;
        byte_q = '{8'hFF};
        build(1'b0);
        load_byte(8'hFF);
        next_sample(done, idx, gl, el, gf, ef);
        while (!done) begin
            if (gf[4] && bc_at < 0) bc_at = idx;
            nvec++;
            if (gl !== el) begin nerr++; $display("FAIL stuff line @%0d: got %b want %b", idx, gl, el); end
            nvec++;
            if (gf !== ef) begin nerr++; $display("FAIL stuff flags @%0d: got %b want %b", idx, gf, ef); end
            next_sample(done, idx, gl, el, gf, ef);
        end
        nvec++;
        if (bc_at != 75) begin
            nerr++;
            $display("FAIL stuff byte_complete clocks: got %0d want 75", bc_at);
        end
    endtask

    task automatic test_cross_stuff;
        bit done; int idx; logic [1:0] gl, el; logic [4:0] gf, ef;
        smp = 0;
        byte_q = '{8'hF0, 8'h03};
        build(1'b0);
        load_byte(8'hF0);
        fork
            begin
                next_sample(done, idx, gl, el, gf, ef);
                while (!done) begin
                    nvec++;
                    if (gl !== el) begin nerr++; $display("FAIL xstuff line @%0d: got %b want %b", idx, gl, el); end
                    nvec++;
                    if (gf !== ef) begin nerr++; $display("FAIL xstuff flags @%0d: got %b want %b", idx, gf, ef); end
                    next_sample(done, idx, gl, el, gf, ef);
                end
            end
            load_byte(8'h03);
        join
    endtask

    task automatic test_back_to_back;
        bit done; int idx, t; logic [1:0] gl, el; logic [4:0] gf, ef;
        smp = 0;
        byte_q = '{8'h5A, 8'hC3, 8'h81};
        build(1'b0);
        load_byte(8'h5A);
        fork
            begin
                next_sample(done, idx, gl, el, gf, ef);
                while (!done) begin
                    nvec++;
                    if (gl !== el) begin nerr++; $display("FAIL b2b line @%0d: got %b want %b", idx, gl, el); end
                    nvec++;
                    if (gf !== ef) begin nerr++; $display("FAIL b2b flags @%0d: got %b want %b", idx, gf, ef); end
                    next_sample(done, idx, gl, el, gf, ef);
                end
            end
            begin
                load_byte(8'hC3);
                t = 0;
                do begin @(negedge clk); t++; end while (!byte_complete && t < 200);
                nvec++;
                if (!byte_complete) begin nerr++; $display("FAIL b2b byte_complete timeout: got 0 want 1"); end
                load_enable = 1'b1;
                data_pts = 8'h81;
                @(negedge clk);
                load_enable = 1'b0;
            end
        join
    endtask

    task automatic test_overrun;
        bit done; int idx; logic [1:0] gl, el; logic [4:0] gf, ef;
        smp = 0;
        byte_q = '{8'h0F, 8'h01};
        build(1'b0);
        @(negedge clk);
        load_enable = 1'b1;
        data_pts = 8'h0F;
        @(negedge clk);
        data_pts = 8'h01;
        fork
            begin
                next_sample(done, idx, gl, el, gf, ef);
                while (!done) begin
                    ef[0] = (idx == 1);
                    nvec++;
                    if (gl !== el) begin nerr++; $display("FAIL overrun line @%0d: got %b want %b", idx, gl, el); end
                    nvec++;
                    if (gf !== ef) begin nerr++; $display("FAIL overrun flags @%0d: got %b want %b", idx, gf, ef); end
                    next_sample(done, idx, gl, el, gf, ef);
                end
            end
            begin
                @(negedge clk);
                data_pts = 8'hEE;
                @(negedge clk);
                load_enable = 1'b0;
            end
        join
    endtask

    task automatic test_idle_eop;
        bit done; int idx; logic [1:0] gl, el; logic [4:0] gf, ef;
        @(negedge clk);
        eop_request = 1'b1;
        @(negedge clk);
        eop_request = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nvec++;
            if ({dplus, dminus, byte_complete, underrun, eop_done, busy, overrun} !== 7'b1000000) begin
                nerr++;
                $display("FAIL idle_eop @%0d: got %b want 1000000", i,
                         {dplus, dminus, byte_complete, underrun, eop_done, busy, overrun});
            end
        end
        // a latched request would turn this underrun into an EOP
        smp = 0;
        byte_q = '{8'h00};
        build(1'b0);
        load_byte(8'h00);
        next_sample(done, idx, gl, el, gf, ef);
        while (!done) begin
            nvec++;
            if (gl !== el) begin nerr++; $display("FAIL idle_eop line @%0d: got %b want %b", idx, gl, el); end
            nvec++;
            if (gf !== ef) begin nerr++; $display("FAIL idle_eop flags @%0d: got %b want %b", idx, gf, ef); end
            next_sample(done, idx, gl, el, gf, ef);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_eop(8'h80, "sync");
        test_stuffing();
        test_eop(8'hFC, "stuff_eop");
        test_cross_stuff();
        test_back_to_back();
        test_overrun();
        test_idle_eop();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
